vad_multich: RTL



---
 rtl/vad_pkg.sv | 27 ++
 rtl/vad_win_stats.sv | 80 ++++++++
 rtl/vad_multich.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/vad_pkg.sv
// Shared types and helpers for the multi-channel voice activity detector.
package vad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ONSET,
    ST_SPEECH,
    ST_HANG
  } vad_state_e;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Unsigned add clamped to the largest w-bit value (w <= 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    if (sum > lim) return lim[63:0];
    return sum[63:0];
  endfunction

endpackage

// File: rtl/vad_win_stats.sv
// Per-channel window statistics: squared energy, zero crossings and window count.
module vad_win_stats
  import vad_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 16,
  parameter int ACC_W       = 32,
  parameter int WIN_SAMPLES = 160,
  parameter int SQ_SHIFT    = 6,
  parameter int CH_W        = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic [CH_W-1:0]          s_ch,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     close_p0,
  output logic [CH_W-1:0]          close_ch_p0,
  output logic [ACC_W-1:0]         close_energy_p0,
  output logic [15:0]              close_zcr_p0
);

  localparam int CNT_W = (WIN_SAMPLES <= 2) ? 1 : $clog2(WIN_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_SAMPLES - 1);

  logic [ACC_W-1:0] acc       [NUM_CH];
  logic [15:0]      zcr       [NUM_CH];
  logic [CNT_W-1:0] cnt       [NUM_CH];
  logic [NUM_CH-1:0] last_sign;

  logic signed [2*DATA_W-1:0] prod_p0;
  logic [2*DATA_W-1:0]        sq_p0;
  logic                       ch_ok_p0;
  logic                       sign_p0;
  logic                       nz_p0;
  logic                       cross_p0;
  logic [ACC_W-1:0]           acc_nxt_p0;
  logic [15:0]                zcr_nxt_p0;

  // Stage p0: combine the incoming sample with the channel's running totals
  always_comb begin
    prod_p0    = s_data * s_data;
    sq_p0      = $unsigned(prod_p0) >> SQ_SHIFT;
    ch_ok_p0   = s_valid && (32'(s_ch) < 32'(NUM_CH));
    sign_p0    = s_data[DATA_W-1];
    nz_p0      = (s_data != '0);
    cross_p0   = nz_p0 && (sign_p0 != last_sign[s_ch]);
    acc_nxt_p0 = ACC_W'(sat_add(64'(acc[s_ch]), 64'(sq_p0), ACC_W));
    zcr_nxt_p0 = zcr[s_ch] + {15'd0, cross_p0};

    close_p0        = ch_ok_p0 && (cnt[s_ch] == CNT_LAST);
    close_ch_p0     = s_ch;
    close_energy_p0 = acc_nxt_p0;
    close_zcr_p0    = zcr_nxt_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        zcr[i] <= '0;
        cnt[i] <= '0;
      end
      last_sign <= '0;
    end else if (ch_ok_p0) begin
      // A zero sample carries no sign, so the previous polarity is kept
      if (nz_p0) last_sign[s_ch] <= sign_p0;
      if (close_p0) begin
        acc[s_ch] <= '0;
        zcr[s_ch] <= '0;
        cnt[s_ch] <= '0;
      end else begin
        acc[s_ch] <= acc_nxt_p0;
        zcr[s_ch] <= zcr_nxt_p0;
        cnt[s_ch] <= cnt[s_ch] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vad_multich.sv
// Multi-channel voice activity detector: window stats feed a per-channel noise floor and speech FSM.
module vad_multich
  import vad_pkg::*;
#(
  parameter int               NUM_CH      = 4,
  parameter int               DATA_W      = 16,
  parameter int               ACC_W       = 32,
  parameter int               WIN_SAMPLES = 160,
  parameter int               SQ_SHIFT    = 6,
  parameter logic [ACC_W-1:0] NF_INIT     = 32'd4096,
  parameter int               ADAPT_SHIFT = 4,
  parameter int               ON_SHIFT    = 2,
  parameter int               OFF_SHIFT   = 1,
  parameter int               ZCR_MIN     = 15,
  parameter int               ZCR_MAX     = 45,
  parameter int               ONSET_WIN   = 2,
  parameter int               HANG_WIN    = 30,
  localparam int              CH_W        = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic [CH_W-1:0]          s_ch,
  input  logic signed [DATA_W-1:0] s_data,
  output logic [NUM_CH-1:0]        speech,
  output logic                     any_speech,
  output logic                     evt_valid,
  output logic [CH_W-1:0]          evt_ch,
  output logic                     evt_start,
  output logic                     win_valid,
  output logic [CH_W-1:0]          win_ch,
  output logic [ACC_W-1:0]         win_energy,
  output logic [15:0]              win_zcr,
  output logic [ACC_W-1:0]         noise_floor
);

  localparam int THR_W = ACC_W + ((ON_SHIFT > OFF_SHIFT) ? ON_SHIFT : OFF_SHIFT);
  localparam int ON_W  = $clog2(ONSET_WIN + 1);
  localparam int HG_W  = $clog2(HANG_WIN + 1);

  logic             close_p0;
  logic [CH_W-1:0]  close_ch_p0;
  logic [ACC_W-1:0] close_energy_p0;
  logic [15:0]      close_zcr_p0;

  vad_win_stats #(
    .NUM_CH      (NUM_CH),
    .DATA_W      (DATA_W),
    .ACC_W       (ACC_W),
    .WIN_SAMPLES (WIN_SAMPLES),
    .SQ_SHIFT    (SQ_SHIFT),
    .CH_W        (CH_W)
  ) u_stats (
    .clk             (clk),
    .rst             (rst),
    .s_valid         (s_valid),
    .s_ch            (s_ch),
    .s_data          (s_data),
    .close_p0        (close_p0),
    .close_ch_p0     (close_ch_p0),
    .close_energy_p0 (close_energy_p0),
    .close_zcr_p0    (close_zcr_p0)
  );

  vad_state_e       state    [NUM_CH];
  logic [ON_W-1:0]  on_cnt   [NUM_CH];
  logic [HG_W-1:0]  hang_cnt [NUM_CH];
  logic [ACC_W-1:0] nf       [NUM_CH];

  vad_state_e        st_cur_p0;
  vad_state_e        st_nxt_p0;
  logic [ON_W-1:0]   on_nxt_p0;
  logic [HG_W-1:0]   hang_nxt_p0;
  logic [ACC_W-1:0]  nf_cur_p0;
  logic [ACC_W-1:0]  nf_nxt_p0;
  logic [THR_W-1:0]  e_thr_p0;
  logic [THR_W-1:0]  on_thr_p0;
  logic [THR_W-1:0]  off_thr_p0;
  logic              sw_p0;
  logic              rel_p0;
  logic              evt_fire_p0;
  logic              evt_kind_p0;
  logic [NUM_CH-1:0] speech_nxt_p0;

  logic              win_vld_p1;
  logic [CH_W-1:0]   win_ch_p1;
  logic [ACC_W-1:0]  win_energy_p1;
  logic [15:0]       win_zcr_p1;
  logic [ACC_W-1:0]  nf_out_p1;
  logic              evt_vld_p1;
  logic [CH_W-1:0]   evt_ch_p1;
  logic              evt_start_p1;
  logic [NUM_CH-1:0] speech_p1;
  logic              any_p1;

  // Stage p0: window decision for the channel whose window is closing
  always_comb begin
    st_cur_p0  = state[close_ch_p0];
    nf_cur_p0  = nf[close_ch_p0];
    e_thr_p0   = THR_W'(close_energy_p0);
    on_thr_p0  = THR_W'(nf_cur_p0) << ON_SHIFT;
    off_thr_p0 = THR_W'(nf_cur_p0) << OFF_SHIFT;
    sw_p0      = (e_thr_p0 > on_thr_p0) &&
                 (close_zcr_p0 >= 16'(ZCR_MIN)) && (close_zcr_p0 <= 16'(ZCR_MAX));
    rel_p0     = (e_thr_p0 < off_thr_p0);

    nf_nxt_p0 = nf_cur_p0;
    if (st_cur_p0 == ST_IDLE) begin
      if (close_energy_p0 < nf_cur_p0) nf_nxt_p0 = close_energy_p0;
      else nf_nxt_p0 = nf_cur_p0 + ((close_energy_p0 - nf_cur_p0) >> ADAPT_SHIFT);
    end

    st_nxt_p0   = st_cur_p0;
    on_nxt_p0   = on_cnt[close_ch_p0];
    hang_nxt_p0 = hang_cnt[close_ch_p0];
    evt_fire_p0 = 1'b0;
    evt_kind_p0 = 1'b0;
    case (st_cur_p0)
      ST_IDLE: begin
        if (sw_p0) begin
          if (ONSET_WIN <= 1) begin
            st_nxt_p0   = ST_SPEECH;
            evt_fire_p0 = 1'b1;
            evt_kind_p0 = 1'b1;
          end else begin
            st_nxt_p0 = ST_ONSET;
            on_nxt_p0 = ON_W'(1);
          end
        end
      end
      ST_ONSET: begin
        if (sw_p0) begin
          on_nxt_p0 = on_cnt[close_ch_p0] + 1'b1;
          if (32'(on_cnt[close_ch_p0]) + 1 >= ONSET_WIN) begin
            st_nxt_p0   = ST_SPEECH;
            evt_fire_p0 = 1'b1;
            evt_kind_p0 = 1'b1;
          end
        end else begin
          st_nxt_p0 = ST_IDLE;
        end
      end
      ST_SPEECH: begin
        if (rel_p0) begin
          st_nxt_p0   = ST_HANG;
          hang_nxt_p0 = HG_W'(HANG_WIN);
        end
      end
      ST_HANG: begin
        if (sw_p0) begin
          st_nxt_p0 = ST_SPEECH;
        end else if (hang_cnt[close_ch_p0] <= HG_W'(1)) begin
          st_nxt_p0   = ST_IDLE;
          evt_fire_p0 = 1'b1;
          evt_kind_p0 = 1'b0;
        end else begin
          hang_nxt_p0 = hang_cnt[close_ch_p0] - 1'b1;
        end
      end
      default: st_nxt_p0 = ST_IDLE;
    endcase

    speech_nxt_p0 = speech_p1;
    speech_nxt_p0[close_ch_p0] = (st_nxt_p0 == ST_SPEECH) || (st_nxt_p0 == ST_HANG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]    <= ST_IDLE;
        on_cnt[i]   <= '0;
        hang_cnt[i] <= '0;
        nf[i]       <= NF_INIT;
      end
    end else if (close_p0) begin
      state[close_ch_p0]    <= st_nxt_p0;
      on_cnt[close_ch_p0]   <= on_nxt_p0;
      hang_cnt[close_ch_p0] <= hang_nxt_p0;
      nf[close_ch_p0]       <= nf_nxt_p0;
    end
  end

  // Stage p1: registered window report, events and speech flags
  always_ff @(posedge clk) begin
    if (rst) begin
      win_vld_p1    <= 1'b0;
      win_ch_p1     <= '0;
      win_energy_p1 <= '0;
      win_zcr_p1    <= '0;
      nf_out_p1     <= '0;
      evt_vld_p1    <= 1'b0;
      evt_ch_p1     <= '0;
      evt_start_p1  <= 1'b0;
      speech_p1     <= '0;
      any_p1        <= 1'b0;
    end else begin
      win_vld_p1 <= close_p0;
      evt_vld_p1 <= close_p0 && evt_fire_p0;
      if (close_p0) begin
        win_ch_p1     <= close_ch_p0;
        win_energy_p1 <= close_energy_p0;
        win_zcr_p1    <= close_zcr_p0;
        nf_out_p1     <= nf_nxt_p0;
        speech_p1     <= speech_nxt_p0;
        any_p1        <= |speech_nxt_p0;
        if (evt_fire_p0) begin
          evt_ch_p1    <= close_ch_p0;
          evt_start_p1 <= evt_kind_p0;
        end
      end
    end
  end

  assign win_valid   = win_vld_p1;
  assign win_ch      = win_ch_p1;
  assign win_energy  = win_energy_p1;
  assign win_zcr     = win_zcr_p1;
  assign noise_floor = nf_out_p1;
  assign evt_valid   = evt_vld_p1;
  assign evt_ch      = evt_ch_p1;
  assign evt_start   = evt_start_p1;
  assign speech      = speech_p1;
  assign any_speech  = any_p1;

endmodule
